test_signal_gen: RTL

TEST_SIGNAL_GEN -- requirements
Module: test_signal_gen

---
 rtl/test_signal_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/test_signal_gen.sv
// Test signal generator: DC, triangle, impulse and square test tones on a
// programmable sample strobe, with a registered PCM bypass path.
module test_signal_gen #(
    parameter int DATA_W = 24,
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 11
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic [DIV_W-1:0]           smp_div,
    input  logic [3:0]                 mode,
    input  logic [DATA_W-1:0]          tri_inc,
    input  logic [9:0]                 pulse_period,
    input  logic [NUM_CH-1:0]          ch_invert,
    input  logic                       pcm_valid,
    input  logic [NUM_CH*DATA_W-1:0]   pcm_data,
    output logic                       out_valid,
    output logic [NUM_CH*DATA_W-1:0]   out_data
);

    localparam int AW = DATA_W + 2;
    localparam logic signed [DATA_W-1:0] MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] NEG = -MAX;
    localparam logic signed [AW-1:0] MAX_X = {2'b00, MAX};
    localparam logic signed [AW-1:0] NEG_X = {2'b11, NEG};

    logic [DIV_W-1:0]          cnt;
    logic                      strobe;
    logic signed [DATA_W-1:0]  acc;
    logic                      dir_dn;
    logic [9:0]                pc;
    logic [3:0]                mode_q;

    logic                      mode_chg;
    logic signed [DATA_W-1:0]  acc_c;
    logic                      dir_c;
    logic [9:0]                pc_c;
    logic signed [AW-1:0]      acc_x;
    logic signed [AW-1:0]      inc_x;
    logic signed [AW-1:0]      up_sum;
    logic signed [AW-1:0]      dn_sum;
    logic signed [DATA_W-1:0]  acc_n;
    logic                      dir_n;
    logic [9:0]                pc_n;
    logic [10:0]               half;
    logic signed [DATA_W-1:0]  sample;
    logic [NUM_CH*DATA_W-1:0]  gen_data;

    assign strobe = run && (cnt >= smp_div);

    // A mode change restarts the generators; if a strobe lands on the same
    // cycle it steps from the restarted state.
    always_comb begin
        mode_chg = (mode != mode_q);
        acc_c    = mode_chg ? '0 : acc;
        dir_c    = mode_chg ? 1'b0 : dir_dn;
        pc_c     = mode_chg ? '0 : pc;
        acc_x    = {{2{acc_c[DATA_W-1]}}, acc_c};
        inc_x    = {2'b00, tri_inc};
        up_sum   = acc_x + inc_x;
        dn_sum   = acc_x - inc_x;
        acc_n    = acc_c;
        dir_n    = dir_c;
        if (!dir_c) begin
            if (up_sum >= MAX_X) begin
                acc_n = MAX;
                dir_n = 1'b1;
            end else begin
                acc_n = up_sum[DATA_W-1:0];
            end
        end else begin
            if (dn_sum <= NEG_X) begin
                acc_n = NEG;
                dir_n = 1'b0;
            end else begin
                acc_n = dn_sum[DATA_W-1:0];
            end
        end
        pc_n = (pc_c >= pulse_period) ? '0 : pc_c + 10'd1;
        half = ({1'b0, pulse_period} + 11'd1) >> 1;
    end

    always_comb begin
        sample = '0;
        case (mode)
            4'd1:    sample = MAX;
            4'd2:    sample = NEG;
            4'd3:    sample = acc_n;
            4'd4:    sample = (pc_c == '0) ? MAX : '0;
            4'd5:    sample = ({1'b0, pc_c} < half) ? MAX : NEG;
            default: sample = '0;
        endcase
        gen_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            gen_data[c*DATA_W +: DATA_W] = ch_invert[c] ? -sample : sample;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            dir_dn <= 1'b0;
            pc     <= '0;
            mode_q <= '0;
        end else begin
            mode_q <= mode;
            if (!run) begin
                cnt    <= '0;
                acc    <= '0;
                dir_dn <= 1'b0;
                pc     <= '0;
            end else begin
                cnt <= strobe ? '0 : cnt + {{(DIV_W-1){1'b0}}, 1'b1};
                if (strobe) begin
                    acc    <= acc_n;
                    dir_dn <= dir_n;
                    pc     <= pc_n;
                end else if (mode_chg) begin
                    acc    <= '0;
                    dir_dn <= 1'b0;
                    pc     <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (mode == 4'd0) begin
            out_valid <= pcm_valid;
            out_data  <= pcm_data;
        end else if (!run) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= strobe;
            if (strobe) out_data <= gen_data;
        end
    end

endmodule
